// File: rtl/dpu_issue_ctrl_if.sv
// Request, unit-drive and result bus of the dot-product issue controller.
// The controller takes the slave modport; the requester/unit/consumer side takes master.
interface dpu_issue_ctrl_if #(
  parameter int VECTOR_LANES = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int TAG_WIDTH    = 4
);
  localparam int VW = VECTOR_LANES * DATA_WIDTH;

  logic                 req_valid;
  logic                 req_ready;
  logic [2:0]           req_funct;
  logic [2:0]           req_rnd;
  logic [TAG_WIDTH-1:0] req_tag;
  logic                 dpu_en;
  logic [2:0]           dpu_funct;
  logic [2:0]           dpu_rnd;
  logic [VW-1:0]        dpu_vec_out;
  logic                 res_valid;
  logic                 res_ready;
  logic [VW-1:0]        res_data;
  logic [TAG_WIDTH-1:0] res_tag;
  logic                 err_illegal;
  logic                 busy;

  modport slave (
    input  req_valid, req_funct, req_rnd, req_tag, dpu_vec_out, res_ready,
    output req_ready, dpu_en, dpu_funct, dpu_rnd, res_valid, res_data, res_tag,
           err_illegal, busy
  );

  modport master (
    output req_valid, req_funct, req_rnd, req_tag, dpu_vec_out, res_ready,
    input  req_ready, dpu_en, dpu_funct, dpu_rnd, res_valid, res_data, res_tag,
           err_illegal, busy
  );
endinterface

// File: rtl/dpu_issue_ctrl.sv
// Issue/writeback controller for the non-stalling pipelined FP dot-product unit.
// Credits (in-flight + FIFO occupancy) bound issue so every result has a FIFO slot.
module dpu_issue_ctrl #(
  parameter int VECTOR_LANES = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int PIPE_LAT     = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int TAG_WIDTH    = 4
) (
  input logic             clk,
  input logic             rst_n,
  dpu_issue_ctrl_if.slave bus
);
  localparam int VW = VECTOR_LANES * DATA_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [TAG_WIDTH-1:0] tag;
    logic [VW-1:0]        data;
  } res_t;

  logic [PIPE_LAT-1:0]                r_vld_pipe;
  logic [PIPE_LAT-1:0][TAG_WIDTH-1:0] r_tag_pipe;
  res_t                               r_mem [FIFO_DEPTH];
  logic [PW-1:0]                      r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]                      r_cnt;
  logic                               r_err;

  logic [CW-1:0] w_inflight;
  logic          w_ready, w_fire, w_issue, w_bad, w_push, w_pop, w_full;

  function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < PIPE_LAT; i++) w_inflight = w_inflight + CW'(r_vld_pipe[i]);
  end

  // Credit check uses registered state only; a same-cycle pop frees nothing yet.
  assign w_ready = ({1'b0, w_inflight} + {1'b0, r_cnt}) < DEPTH_C;
  assign w_fire  = bus.req_valid & w_ready;
  assign w_issue = w_fire & ~bus.req_funct[2];
  assign w_bad   = w_fire &  bus.req_funct[2];
  assign w_push  = r_vld_pipe[PIPE_LAT-1];
  assign w_full  = (r_cnt == CW'(FIFO_DEPTH));
  assign w_pop   = bus.res_valid & bus.res_ready;

  assign bus.req_ready   = w_ready;
  assign bus.dpu_en      = w_issue;
  assign bus.dpu_funct   = w_issue ? bus.req_funct : 3'd0;
  assign bus.dpu_rnd     = w_issue ? bus.req_rnd   : 3'd0;
  assign bus.res_valid   = (r_cnt != '0);
  assign bus.res_data    = r_mem[r_rd_ptr].data;
  assign bus.res_tag     = r_mem[r_rd_ptr].tag;
  assign bus.err_illegal = r_err;
  assign bus.busy        = (w_inflight != '0) | (r_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_tag_pipe <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_vld_pipe[0] <= w_issue;
      r_tag_pipe[0] <= bus.req_tag;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_tag_pipe[i] <= r_tag_pipe[i-1];
      end
      if (w_push) r_wr_ptr <= ptr_nxt(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_nxt(r_rd_ptr);
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
      r_err <= w_bad;
    end
  end

  // Storage needs no reset: nothing is visible until r_cnt says so.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{tag: r_tag_pipe[PIPE_LAT-1], data: bus.dpu_vec_out};
  end

  ap_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(w_push && w_full));

endmodule

// File: tb/tb_dpu_issue_ctrl.sv
// Directed bench for dpu_issue_ctrl: inputs driven at negedge, outputs sampled 1ns later.
// The unit result bus carries a cycle-stamped pattern so each result's push cycle is checkable.
module tb_dpu_issue_ctrl;
  localparam int VL = 16, DW = 32, PL = 2, FD = 4, TW = 4, VW = VL * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_run = 0, n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dpu_issue_ctrl_if #(.VECTOR_LANES(VL), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

  dpu_issue_ctrl #(
    .VECTOR_LANES(VL), .DATA_WIDTH(DW), .PIPE_LAT(PL), .FIFO_DEPTH(FD), .TAG_WIDTH(TW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic logic [VW-1:0] mkvec(input int c);
    logic [VW-1:0] v;
    for (int l = 0; l < VL; l++) v[l*DW +: DW] = 32'hC0DE_0000 + 32'(c * 16 + l);
    return v;
  endfunction

  assign bus.dpu_vec_out = mkvec(cyc);

  task automatic test_reset();
    repeat (2) @(negedge clk);
    bus.req_funct = 3'd3; bus.req_rnd = 3'd5;
    #1;
    n_run++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got %b exp 0", bus.res_valid); end
    n_run++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    n_run++; if (bus.err_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", bus.err_illegal); end
    @(negedge clk); rst_n = 1'b1; #1;
    n_run++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b exp 1", bus.req_ready); end
    n_run++; if (bus.dpu_en !== 1'b0) begin n_fail++; $display("FAIL idle_dpu_en got %b exp 0", bus.dpu_en); end
    n_run++; if (bus.dpu_funct !== 3'd0 || bus.dpu_rnd !== 3'd0) begin
      n_fail++; $display("FAIL idle_funct_rnd got %0d/%0d exp 0/0", bus.dpu_funct, bus.dpu_rnd); end
    bus.req_funct = 3'd0; bus.req_rnd = 3'd0;
  endtask

  task automatic test_latency();
    int t;
    @(negedge clk);
    bus.res_ready = 1'b1; bus.req_valid = 1'b1; bus.req_funct = 3'd0; bus.req_rnd = 3'd6; bus.req_tag = 4'd3;
    #1; t = cyc;
    n_run++; if (bus.dpu_en !== 1'b1) begin n_fail++; $display("FAIL lat_dpu_en got %b exp 1", bus.dpu_en); end
    n_run++; if (bus.dpu_rnd !== 3'd6 || bus.dpu_funct !== 3'd0) begin
      n_fail++; $display("FAIL lat_funct_rnd got %0d/%0d exp 0/6", bus.dpu_funct, bus.dpu_rnd); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); bus.req_valid = 1'b0; #1;
      n_run++; if (bus.res_valid !== (k == 3)) begin
        n_fail++; $display("FAIL lat_res_valid cycle t+%0d got %b exp %b", k, bus.res_valid, (k == 3)); end
      if (k == 3) begin
        n_run++; if (bus.res_tag !== 4'd3) begin n_fail++; $display("FAIL lat_tag got %0d exp 3", bus.res_tag); end
        n_run++; if (bus.res_data !== mkvec(t + 2)) begin
          n_fail++; $display("FAIL lat_data got %h exp %h", bus.res_data, mkvec(t + 2)); end
      end
    end
    n_run++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL lat_busy_after got %b exp 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    int t0;
    bit ev;
    t0 = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      bus.res_ready = 1'b1; bus.req_valid = (c < 4); bus.req_funct = 3'd1; bus.req_tag = TW'(c);
      #1;
      if (c == 0) t0 = cyc;
      if (c < 4) begin
        n_run++; if (bus.req_ready !== 1'b1 || bus.dpu_en !== 1'b1) begin
          n_fail++; $display("FAIL b2b_issue c%0d ready/en got %b/%b exp 1/1", c, bus.req_ready, bus.dpu_en); end
      end
      ev = (c >= 3 && c <= 6);
      n_run++; if (bus.res_valid !== ev) begin
        n_fail++; $display("FAIL b2b_res_valid c%0d got %b exp %b", c, bus.res_valid, ev); end
      if (ev) begin
        n_run++; if (bus.res_tag !== TW'(c - 3) || bus.res_data !== mkvec(t0 + c - 1)) begin
          n_fail++; $display("FAIL b2b_result c%0d tag got %0d exp %0d data got %h exp %h",
                             c, bus.res_tag, c - 3, bus.res_data, mkvec(t0 + c - 1)); end
      end
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int iss [8];
    int acc, got;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bus.res_ready = 1'b0; bus.req_valid = 1'b1; bus.req_funct = 3'd2; bus.req_tag = TW'(acc);
      #1;
      n_run++; if (bus.req_ready !== (c < 4)) begin
        n_fail++; $display("FAIL bp_fill_ready c%0d got %b exp %b", c, bus.req_ready, (c < 4)); end
      if (bus.req_ready && acc < 4) begin iss[acc] = cyc; acc++; end
    end
    n_run++; if (acc != 4) begin n_fail++; $display("FAIL bp_accepted got %0d exp 4", acc); end
    @(negedge clk); bus.res_ready = 1'b1; bus.req_tag = 4'd4; #1;
    n_run++; if (bus.res_valid !== 1'b1 || bus.res_tag !== 4'd0 || bus.res_data !== mkvec(iss[0] + 2)) begin
      n_fail++; $display("FAIL bp_pop_head valid %b tag got %0d exp 0", bus.res_valid, bus.res_tag); end
    n_run++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_pop_same_cycle_ready got %b exp 0", bus.req_ready); end
    @(negedge clk); bus.res_ready = 1'b0; #1;
    n_run++; if (bus.req_ready !== 1'b1 || bus.dpu_en !== 1'b1) begin
      n_fail++; $display("FAIL bp_fifth_issue ready/en got %b/%b exp 1/1", bus.req_ready, bus.dpu_en); end
    iss[4] = cyc;
    @(negedge clk); bus.req_valid = 1'b0; #1;
    n_run++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_again got %b exp 0", bus.req_ready); end
    got = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); bus.res_ready = 1'b1; #1;
      if (bus.res_valid === 1'b1) begin
        if (got < 4) begin
          n_run++; if (bus.res_tag !== TW'(got + 1) || bus.res_data !== mkvec(iss[got + 1] + 2)) begin
            n_fail++; $display("FAIL bp_drain_order tag got %0d exp %0d", bus.res_tag, got + 1); end
        end
        got++;
      end
    end
    n_run++; if (got != 4) begin n_fail++; $display("FAIL bp_drain_count got %0d exp 4", got); end
    n_run++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy_after got %b exp 0", bus.busy); end
    bus.res_ready = 1'b0;
  endtask

  task automatic test_simul_pushpop();
    int a;
    @(negedge clk); bus.res_ready = 1'b0; bus.req_valid = 1'b1; bus.req_funct = 3'd3; bus.req_tag = 4'd5; #1;
    a = cyc;
    @(negedge clk); bus.req_tag = 4'd6; #1;
    @(negedge clk); bus.req_valid = 1'b0; #1;
    n_run++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL sp_early_valid got %b exp 0", bus.res_valid); end
    @(negedge clk); bus.res_ready = 1'b1; #1;
    n_run++; if (bus.res_valid !== 1'b1 || bus.res_tag !== 4'd5) begin
      n_fail++; $display("FAIL sp_head_a valid %b tag got %0d exp 5", bus.res_valid, bus.res_tag); end
    @(negedge clk); bus.res_ready = 1'b0; #1;
    n_run++; if (bus.res_valid !== 1'b1 || bus.res_tag !== 4'd6 || bus.res_data !== mkvec(a + 3)) begin
      n_fail++; $display("FAIL sp_head_b valid %b tag got %0d exp 6 data got %h exp %h",
                         bus.res_valid, bus.res_tag, bus.res_data, mkvec(a + 3)); end
    @(negedge clk); bus.res_ready = 1'b1; #1;
    @(negedge clk); bus.res_ready = 1'b0; #1;
    n_run++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL sp_count_one valid/busy got %b/%b exp 0/0", bus.res_valid, bus.busy); end
  endtask

  task automatic test_illegal();
    int got;
    @(negedge clk);
    bus.res_ready = 1'b0; bus.req_valid = 1'b1; bus.req_funct = 3'd5; bus.req_rnd = 3'd2; bus.req_tag = 4'd9;
    #1;
    n_run++; if (bus.req_ready !== 1'b1 || bus.dpu_en !== 1'b0 || bus.dpu_funct !== 3'd0) begin
      n_fail++; $display("FAIL ill_fire ready/en/funct got %b/%b/%0d exp 1/0/0", bus.req_ready, bus.dpu_en, bus.dpu_funct); end
    n_run++; if (bus.err_illegal !== 1'b0) begin n_fail++; $display("FAIL ill_err_early got %b exp 0", bus.err_illegal); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); bus.req_funct = 3'd3; bus.req_tag = TW'(k); #1;
      n_run++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL ill_credit k%0d got %b exp 1", k, bus.req_ready); end
      n_run++; if (bus.err_illegal !== (k == 0)) begin
        n_fail++; $display("FAIL ill_err_pulse k%0d got %b exp %b", k, bus.err_illegal, (k == 0)); end
    end
    @(negedge clk); bus.req_funct = 3'd0; #1;
    n_run++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL ill_full got %b exp 0", bus.req_ready); end
    bus.req_valid = 1'b0;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); bus.res_ready = 1'b1; #1;
      if (bus.res_valid === 1'b1) begin
        n_run++; if (bus.res_tag !== TW'(got)) begin n_fail++; $display("FAIL ill_drain tag got %0d exp %0d", bus.res_tag, got); end
        got++;
      end
    end
    n_run++; if (got != 4) begin n_fail++; $display("FAIL ill_result_count got %0d exp 4", got); end
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset_midflight();
    @(negedge clk); bus.res_ready = 1'b1; bus.req_valid = 1'b1; bus.req_funct = 3'd0; bus.req_tag = 4'd1; #1;
    @(negedge clk); bus.req_tag = 4'd2; #1;
    n_run++; if (bus.dpu_en !== 1'b1) begin n_fail++; $display("FAIL rmf_issue got %b exp 1", bus.dpu_en); end
    #2; rst_n = 1'b0; bus.req_valid = 1'b0;
    @(negedge clk); #1;
    n_run++; if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin
      n_fail++; $display("FAIL rmf_in_reset busy/valid got %b/%b exp 0/0", bus.busy, bus.res_valid); end
    @(negedge clk); rst_n = 1'b1; #1;
    n_run++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rmf_ready got %b exp 1", bus.req_ready); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      n_run++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++; $display("FAIL rmf_quiet k%0d valid/busy got %b/%b exp 0/0", k, bus.res_valid, bus.busy); end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_funct = 3'd0; bus.req_rnd = 3'd0; bus.req_tag = '0; bus.res_ready = 1'b0;
    test_reset();
    test_latency();
    test_back_to_back();
    test_backpressure();
    test_simul_pushpop();
    test_illegal();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
